mem_access_unit: RTL and testbench

- Next-generation MEM-stage memory access controller. Sits between the EX/MEM pipeline register and the CPU bus master port.
- Adds byte and halfword loads/stores with byte enables, sign/zero extension, a multi-cycle ready handshake with a pipeline stall request, and a bus timeout.
- Data width is parametrised to 32 or 64 bits.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and bus-side signal bundle for mem_access_unit.
// The slave modport is the unit itself; the master side is the pipeline/bus environment.
`timescale 1ns/1ps
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    localparam int BE_W   = DATA_W / 8;
    localparam int OFS_W  = $clog2(BE_W);
    localparam int ADDR_W = DATA_W - OFS_W;

    logic              ex_en;
    logic [3:0]        ex_mem_op;
    logic [DATA_W-1:0] ex_mem_wr_data;
    logic [DATA_W-1:0] ex_out;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic [DATA_W-1:0] out;
    logic              miss_align;
    logic              bus_err;

    modport master (
        output ex_en, ex_mem_op, ex_mem_wr_data, ex_out, rd_data, rdy_,
        input  addr, as_, rw, be, wr_data, busy, out, miss_align, bus_err
    );

    modport slave (
        input  ex_en, ex_mem_op, ex_mem_wr_data, ex_out, rd_data, rdy_,
        output addr, as_, rw, be, wr_data, busy, out, miss_align, bus_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage memory access controller: byte/half/word loads and stores over a
// ready-handshake bus, with sign/zero extension, stall request and bus timeout.
`timescale 1ns/1ps
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    mem_access_unit_if.slave  bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int OFS_W  = $clog2(BE_W);
    localparam int ADDR_W = DATA_W - OFS_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [BE_W-1:0]  BE_B_TOP = {1'b1, {(BE_W-1){1'b0}}};
    localparam logic [BE_W-1:0]  BE_H_TOP = {2'b11, {(BE_W-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
    typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} size_e;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0, OP_LDW = 4'd1, OP_STW = 4'd2, OP_LDH = 4'd3, OP_LDHU = 4'd4,
        OP_LDB  = 4'd5, OP_LDBU = 4'd6, OP_STH = 4'd7, OP_STB = 4'd8
    } mem_op_e;

    state_e            state_q, state_d;
    logic              as_q, as_d;
    logic              rw_q, rw_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    size_e             size_q, size_d;
    logic              sext_q, sext_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;

    logic              is_load, is_store, sext;
    size_e             size;
    logic [OFS_W-1:0]  ofs;
    logic              aligned, req;
    logic [BE_W-1:0]   be_req;
    logic [DATA_W-1:0] wr_req;
    logic [DATA_W-1:0] rd_shift, ld_val;
    logic [DATA_W-1:0] out_c;
    logic              busy_c, miss_c;

    assign ofs = bus.ex_out[OFS_W-1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (bus.ex_mem_op)
            OP_LDW:  is_load = 1'b1;
            OP_STW:  is_store = 1'b1;
            OP_LDH:  begin is_load = 1'b1; size = SZ_H; sext = 1'b1; end
            OP_LDHU: begin is_load = 1'b1; size = SZ_H; end
            OP_LDB:  begin is_load = 1'b1; size = SZ_B; sext = 1'b1; end
            OP_LDBU: begin is_load = 1'b1; size = SZ_B; end
            OP_STH:  begin is_store = 1'b1; size = SZ_H; end
            OP_STB:  begin is_store = 1'b1; size = SZ_B; end
            default: ;
        endcase
    end

    assign req = bus.ex_en && (is_load || is_store);

    always_comb begin
        aligned = 1'b1;
        be_req  = '1;
        wr_req  = bus.ex_mem_wr_data;
        case (size)
            SZ_H: begin
                aligned = ~ofs[0];
                be_req  = BE_H_TOP >> ofs;
                wr_req  = {(DATA_W/16){bus.ex_mem_wr_data[15:0]}};
            end
            SZ_B: begin
                be_req  = BE_B_TOP >> ofs;
                wr_req  = {BE_W{bus.ex_mem_wr_data[7:0]}};
            end
            default: aligned = (ofs == '0);
        endcase
    end

    // Shift the addressed lane to the top so byte/half extraction is offset-independent.
    assign rd_shift = bus.rd_data << {ofs_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_H:    ld_val = {{(DATA_W-16){sext_q & rd_shift[DATA_W-1]}}, rd_shift[DATA_W-1 -: 16]};
            SZ_B:    ld_val = {{(DATA_W-8){sext_q & rd_shift[DATA_W-1]}}, rd_shift[DATA_W-1 -: 8]};
            default: ld_val = bus.rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            as_q      <= 1'b1;
            rw_q      <= 1'b1;
            be_q      <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            ld_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            size_q    <= SZ_W;
            sext_q    <= 1'b0;
            ofs_q     <= '0;
        end else begin
            state_q   <= state_d;
            as_q      <= as_d;
            rw_q      <= rw_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            ld_q      <= ld_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            ofs_q     <= ofs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        as_d      = as_q;
        rw_d      = rw_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        ld_d      = ld_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        size_d    = size_q;
        sext_d    = sext_q;
        ofs_d     = ofs_q;
        out_c     = '0;
        busy_c    = 1'b0;
        miss_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!req) begin
                    out_c = bus.ex_out;
                end else if (!aligned) begin
                    miss_c = 1'b1;
                end else begin
                    busy_c    = 1'b1;
                    state_d   = BUS;
                    addr_d    = bus.ex_out[DATA_W-1:OFS_W];
                    rw_d      = is_load;
                    as_d      = 1'b0;
                    be_d      = be_req;
                    wr_data_d = wr_req;
                    cnt_d     = '0;
                    size_d    = size;
                    sext_d    = sext;
                    ofs_d     = ofs;
                end
            end
            BUS: begin
                busy_c = 1'b1;
                if (!bus.rdy_) begin
                    as_d    = 1'b1;
                    ld_d    = rw_q ? ld_val : '0;
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    as_d    = 1'b1;
                    err_d   = 1'b1;
                    ld_d    = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_c   = ld_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.addr       = addr_q;
    assign bus.as_        = as_q;
    assign bus.rw         = rw_q;
    assign bus.be         = be_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_c;
    assign bus.out        = out_c;
    assign bus.miss_align = miss_c;
    assign bus.bus_err    = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: 32-bit unit with a short timeout and a 64-bit unit.
`timescale 1ns/1ps
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    typedef struct packed {
        logic [63:0] out;
        logic        err;
    } sb_t;
    sb_t sb_q[$];

    mem_access_unit_if #(.DATA_W(32)) b32 ();
    mem_access_unit_if #(.DATA_W(64)) b64 ();

    mem_access_unit #(.DATA_W(32), .TIMEOUT(4)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    mem_access_unit #(.DATA_W(64))              dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One 32-bit access: pushes its expected result, then drives rdy_ low on BUS cycle wait_n.
    task automatic access32(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                            input logic [29:0] e_addr, input logic [3:0] e_be, input logic e_rw,
                            input logic [31:0] e_wd, input logic chk_wd, input int e_as,
                            input int e_busy, input logic [31:0] e_out, input logic e_err);
        int   busy_n, as_n, k;
        logic done;
        sb_t  exp;
        sb_q.push_back('{out: 64'(e_out), err: e_err});
        @(negedge clk);
        b32.ex_en = 1'b1; b32.ex_mem_op = op; b32.ex_out = a;
        b32.ex_mem_wr_data = wd; b32.rd_data = rd; b32.rdy_ = 1'b1;
        #1;
        busy_n = b32.busy ? 1 : 0;
        as_n = 0; k = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!b32.busy) begin
                done = 1'b1;
                exp = sb_q.pop_front();
                check_eq({tag, "_out"}, 64'(b32.out), exp.out);
                check_eq({tag, "_bus_err"}, 64'(b32.bus_err), 64'(exp.err));
                check_eq({tag, "_miss"}, 64'(b32.miss_align), 64'd0);
            end else begin
                busy_n++;
                if (!b32.as_) begin
                    if (as_n == 0) begin
                        check_eq({tag, "_addr"}, 64'(b32.addr), 64'(e_addr));
                        check_eq({tag, "_be"}, 64'(b32.be), 64'(e_be));
                        check_eq({tag, "_rw"}, 64'(b32.rw), 64'(e_rw));
                        if (chk_wd) check_eq({tag, "_wr_data"}, 64'(b32.wr_data), 64'(e_wd));
                    end
                    as_n++;
                    b32.rdy_ = (k == wait_n) ? 1'b0 : 1'b1;
                    k++;
                end
            end
        end
        check_eq({tag, "_completed"}, 64'(done), 64'd1);
        check_eq({tag, "_as_cycles"}, 64'(as_n), 64'(e_as));
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(e_busy));
        b32.ex_en = 1'b0; b32.rdy_ = 1'b1;
        @(negedge clk);
        check_eq({tag, "_idle_as"}, 64'(b32.as_), 64'd1);
        check_eq({tag, "_idle_err"}, 64'(b32.bus_err), 64'd0);
    endtask

    initial begin
        logic done;
        sb_t  exp;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        b32.ex_en = 1'b0; b32.ex_mem_op = 4'd0; b32.ex_mem_wr_data = '0;
        b32.ex_out = 32'h0000ABCD; b32.rd_data = '0; b32.rdy_ = 1'b1;
        b64.ex_en = 1'b0; b64.ex_mem_op = 4'd0; b64.ex_mem_wr_data = '0;
        b64.ex_out = '0; b64.rd_data = '0; b64.rdy_ = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_as", 64'(b32.as_), 64'd1);
        check_eq("rst_rw", 64'(b32.rw), 64'd1);
        check_eq("rst_be", 64'(b32.be), 64'd0);
        check_eq("rst_addr", 64'(b32.addr), 64'd0);
        check_eq("rst_wr_data", 64'(b32.wr_data), 64'd0);
        check_eq("rst_busy", 64'(b32.busy), 64'd0);
        check_eq("rst_out", 64'(b32.out), 64'h0000ABCD);
        check_eq("rst_bus_err", 64'(b32.bus_err), 64'd0);

        // Reset while a bus cycle is outstanding
        b32.ex_en = 1'b1; b32.ex_mem_op = 4'd1; b32.ex_out = 32'h00000040; b32.rdy_ = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_bus", 64'(b32.as_), 64'd0);
        reset = 1'b0; b32.ex_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_as", 64'(b32.as_), 64'd1);
        check_eq("midrst_be", 64'(b32.be), 64'd0);
        check_eq("midrst_addr", 64'(b32.addr), 64'd0);
        check_eq("midrst_bus_err", 64'(b32.bus_err), 64'd0);
        check_eq("midrst_busy_idle", 64'(b32.busy), 64'd0);
        check_eq("midrst_out", 64'(b32.out), 64'h00000040);
        b32.ex_en = 1'b1;
        #1;
        check_eq("midrst_busy_req", 64'(b32.busy), 64'd1);
        b32.ex_en = 1'b0;
        #1;
        check_eq("midrst_busy_drop", 64'(b32.busy), 64'd0);
        @(negedge clk);
        check_eq("midrst_no_bus", 64'(b32.as_), 64'd1);

        //        tag      op    ex_out        wr_data       rd_data       wait addr        be       rw    exp wr_data  chk as busy out           err
        access32("ldb",   4'd5, 32'h00001003, 32'h0,        32'h11223380, 0, 30'h400,    4'b0001, 1'b1, 32'h0,        0, 1, 2, 32'hFFFFFF80, 1'b0);
        access32("ldbu",  4'd6, 32'h00001003, 32'h0,        32'h11223380, 0, 30'h400,    4'b0001, 1'b1, 32'h0,        0, 1, 2, 32'h00000080, 1'b0);
        access32("sth",   4'd7, 32'h00002002, 32'hDEADBEEF, 32'h12345678, 3, 30'h800,    4'b0011, 1'b0, 32'hBEEFBEEF, 1, 4, 5, 32'h00000000, 1'b0);
        access32("ldw",   4'd1, 32'h00000010, 32'h0,        32'hCAFEF00D, 0, 30'h4,      4'b1111, 1'b1, 32'h0,        0, 1, 2, 32'hCAFEF00D, 1'b0);
        access32("stb",   4'd8, 32'h00000101, 32'h123456A5, 32'hFFFFFFFF, 1, 30'h40,     4'b0100, 1'b0, 32'hA5A5A5A5, 1, 2, 3, 32'h00000000, 1'b0);
        access32("stw",   4'd2, 32'h00000008, 32'h0BADF00D, 32'hFFFFFFFF, 0, 30'h2,      4'b1111, 1'b0, 32'h0BADF00D, 1, 1, 2, 32'h00000000, 1'b0);
        access32("ldh0",  4'd3, 32'h0000000C, 32'h0,        32'h80017FFF, 0, 30'h3,      4'b1100, 1'b1, 32'h0,        0, 1, 2, 32'hFFFF8001, 1'b0);
        access32("ldhu2", 4'd4, 32'h0000000E, 32'h0,        32'h80017FFF, 0, 30'h3,      4'b0011, 1'b1, 32'h0,        0, 1, 2, 32'h00007FFF, 1'b0);
        access32("tmo",   4'd1, 32'h00000020, 32'h0,        32'h55AA55AA, 99, 30'h8,     4'b1111, 1'b1, 32'h0,        0, 4, 5, 32'h00000000, 1'b1);
        access32("tmo_rdy", 4'd1, 32'h00000020, 32'h0,      32'h55AA55AA, 3, 30'h8,      4'b1111, 1'b1, 32'h0,        0, 4, 5, 32'h55AA55AA, 1'b0);

        // Misaligned requests never start a bus cycle
        @(negedge clk);
        b32.ex_en = 1'b1; b32.ex_mem_op = 4'd1; b32.ex_out = 32'h00000002;
        #1;
        check_eq("mis_ldw_flag", 64'(b32.miss_align), 64'd1);
        check_eq("mis_ldw_out", 64'(b32.out), 64'd0);
        check_eq("mis_ldw_busy", 64'(b32.busy), 64'd0);
        @(negedge clk);
        check_eq("mis_ldw_as", 64'(b32.as_), 64'd1);
        b32.ex_mem_op = 4'd3; b32.ex_out = 32'h00000001;
        #1;
        check_eq("mis_ldh_flag", 64'(b32.miss_align), 64'd1);
        check_eq("mis_ldh_out", 64'(b32.out), 64'd0);
        check_eq("mis_ldh_busy", 64'(b32.busy), 64'd0);
        @(negedge clk);
        check_eq("mis_ldh_as", 64'(b32.as_), 64'd1);

        // Pass-through cases
        b32.ex_mem_op = 4'd0; b32.ex_out = 32'h00001234;
        #1;
        check_eq("nop_out", 64'(b32.out), 64'h1234);
        check_eq("nop_busy", 64'(b32.busy), 64'd0);
        check_eq("nop_miss", 64'(b32.miss_align), 64'd0);
        b32.ex_mem_op = 4'hB; b32.ex_out = 32'h00009ABC;
        #1;
        check_eq("badop_out", 64'(b32.out), 64'h9ABC);
        check_eq("badop_busy", 64'(b32.busy), 64'd0);
        b32.ex_en = 1'b0; b32.ex_mem_op = 4'd1; b32.ex_out = 32'h00005678;
        #1;
        check_eq("noen_out", 64'(b32.out), 64'h5678);
        check_eq("noen_busy", 64'(b32.busy), 64'd0);
        @(negedge clk);
        check_eq("noen_as", 64'(b32.as_), 64'd1);

        // 64-bit halfword load at lane offset 6
        sb_q.push_back('{out: 64'hFFFFFFFFFFFF8001, err: 1'b0});
        b64.ex_en = 1'b1; b64.ex_mem_op = 4'd3; b64.ex_out = 64'h0000000000000006;
        b64.rd_data = 64'h0011223344558001; b64.rdy_ = 1'b1;
        #1;
        check_eq("w64_busy_req", 64'(b64.busy), 64'd1);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!b64.busy) begin
                done = 1'b1;
                exp = sb_q.pop_front();
                check_eq("w64_ldh_out", b64.out, exp.out);
                check_eq("w64_ldh_err", 64'(b64.bus_err), 64'(exp.err));
            end else if (!b64.as_) begin
                check_eq("w64_ldh_be", 64'(b64.be), 64'h03);
                check_eq("w64_ldh_addr", 64'(b64.addr), 64'd0);
                b64.rdy_ = 1'b0;
            end
        end
        check_eq("w64_completed", 64'(done), 64'd1);
        b64.ex_en = 1'b0; b64.rdy_ = 1'b1;
        @(negedge clk);
        b64.ex_en = 1'b1; b64.ex_mem_op = 4'd0; b64.ex_out = 64'h0000000000001234;
        #1;
        check_eq("w64_nop_out", b64.out, 64'h1234);
        check_eq("w64_nop_busy", 64'(b64.busy), 64'd0);
        b64.ex_en = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
